// File: rtl/mem_port_arbiter_if.sv
// Bundles both requester ports and the RAM port of the memory arbiter.
// Requester side: req/we/addr/wdata in, gnt/done/rdata out (per requester).
// RAM side: addr/wdata/we/re out of the arbiter, rdata back (sync-read RAM).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // core requester
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic              core_done;
    logic [DATA_W-1:0] core_rdata;

    // ext (loader/debug) requester
    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_gnt;
    logic              ext_done;
    logic [DATA_W-1:0] ext_rdata;

    // RAM port
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  mem_rdata,
        output core_gnt, core_done, core_rdata,
        output ext_gnt, ext_done, ext_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re
    );

    // Requesters + RAM side (used by the environment around the arbiter)
    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output mem_rdata,
        input  core_gnt, core_done, core_rdata,
        input  ext_gnt, ext_done, ext_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one sync-read RAM between core (fixed priority) and ext, with a bounded-wait guard for ext.
// Latency: grant edge -> ACC (1 cycle) -> RESP (1 cycle) -> done pulse + rdata valid; 3-cycle minimum access period.
// Backpressure: level requests wait in place while an access is in flight; they are re-arbitrated at the next IDLE edge.
// Ports: CLK, Reset (async, active-high); bus = mem_port_arbiter_if.slave carrying both requester ports and the RAM port.
module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic                  CLK,
    input  logic                  Reset,
    mem_port_arbiter_if.slave     bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CORE = 2'd1;
    localparam logic [1:0] OWN_EXT  = 2'd2;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [1:0]        state_q,      state_d;
    logic [1:0]        owner_q,      owner_d;
    logic [3:0]        wait_cnt_q,   wait_cnt_d;
    logic              we_q,         we_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0] ext_rdata_q,  ext_rdata_d;
    logic              core_done_q,  core_done_d;
    logic              ext_done_q,   ext_done_d;

    logic ext_forced;

    // ext wins a contended edge only once core has won MAX_WAIT times in a row
    assign ext_forced = bus.ext_req && (wait_cnt_q == WAIT_MAX);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        wait_cnt_d   = wait_cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        core_rdata_d = core_rdata_q;
        ext_rdata_d  = ext_rdata_q;
        core_done_d  = 1'b0;
        ext_done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.core_req && !ext_forced) begin
                    state_d = ST_ACC;
                    owner_d = OWN_CORE;
                    we_d    = bus.core_we;
                    addr_d  = bus.core_addr;
                    wdata_d = bus.core_wdata;
                    // count only wins that made ext wait; ext_forced already
                    // caps the count at WAIT_MAX, so +1 cannot overshoot
                    wait_cnt_d = bus.ext_req ? wait_cnt_q + 4'd1 : 4'd0;
                end else if (bus.ext_req) begin
                    state_d    = ST_ACC;
                    owner_d    = OWN_EXT;
                    we_d       = bus.ext_we;
                    addr_d     = bus.ext_addr;
                    wdata_d    = bus.ext_wdata;
                    wait_cnt_d = 4'd0;
                end else begin
                    wait_cnt_d = 4'd0;
                end
            end
            ST_ACC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                // RAM data launched by the ACC-cycle read is valid now
                if (owner_q == OWN_CORE) begin
                    core_done_d = 1'b1;
                    if (!we_q) core_rdata_d = bus.mem_rdata;
                end else if (owner_q == OWN_EXT) begin
                    ext_done_d = 1'b1;
                    if (!we_q) ext_rdata_d = bus.mem_rdata;
                end
                owner_d = OWN_NONE;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_NONE;
            wait_cnt_q   <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_rdata_q <= '0;
            ext_rdata_q  <= '0;
            core_done_q  <= 1'b0;
            ext_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            wait_cnt_q   <= wait_cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_rdata_q <= core_rdata_d;
            ext_rdata_q  <= ext_rdata_d;
            core_done_q  <= core_done_d;
            ext_done_q   <= ext_done_d;
        end
    end

    logic in_acc;
    logic busy;

    // Strobes decode straight from state so an async reset kills them at once
    assign in_acc = (state_q == ST_ACC);
    assign busy   = (state_q == ST_ACC) || (state_q == ST_RESP);

    assign bus.mem_we    = in_acc && we_q;
    assign bus.mem_re    = in_acc && !we_q;
    assign bus.mem_addr  = in_acc ? addr_q  : '0;
    assign bus.mem_wdata = in_acc ? wdata_q : '0;

    assign bus.core_gnt   = busy && (owner_q == OWN_CORE);
    assign bus.ext_gnt    = busy && (owner_q == OWN_EXT);
    assign bus.core_done  = core_done_q;
    assign bus.ext_done   = ext_done_q;
    assign bus.core_rdata = core_rdata_q;
    assign bus.ext_rdata  = ext_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic CLK;
    logic Reset;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(4)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    int checks;
    int errors;

    logic [15:0] ram [256];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous-read RAM model: read data valid the cycle after mem_re
    always @(posedge CLK) begin
        if (bus.mem_we) ram[bus.mem_addr[7:0]] = bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.core_req   = 1'b0;
        bus.core_we    = 1'b0;
        bus.core_addr  = 16'h0;
        bus.core_wdata = 16'h0;
        bus.ext_req    = 1'b0;
        bus.ext_we     = 1'b0;
        bus.ext_addr   = 16'h0;
        bus.ext_wdata  = 16'h0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        idle_inputs();
        #1;
        checks++;
        if ({bus.core_gnt, bus.ext_gnt, bus.core_done, bus.ext_done, bus.mem_we, bus.mem_re} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {bus.core_gnt, bus.ext_gnt, bus.core_done, bus.ext_done, bus.mem_we, bus.mem_re});
        end
        checks++;
        if ({bus.core_rdata, bus.ext_rdata, bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0",
                     {bus.core_rdata, bus.ext_rdata, bus.mem_addr, bus.mem_wdata});
        end
        tick();
        tick();
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_core_read();
        bus.core_req  = 1'b1;
        bus.core_we   = 1'b0;
        bus.core_addr = 16'h0010;
        tick(); // e0: ACC
        bus.core_req  = 1'b0;
        bus.core_addr = 16'h00AA;
        checks++;
        if ({bus.mem_re, bus.mem_we, bus.core_gnt, bus.ext_gnt} !== 4'b1010 || bus.mem_addr !== 16'h0010) begin
            errors++;
            $display("FAIL core_read_acc: re/we/cg/eg=%b addr=%h want 1010 0010",
                     {bus.mem_re, bus.mem_we, bus.core_gnt, bus.ext_gnt}, bus.mem_addr);
        end
        tick(); // e1: RESP
        checks++;
        if ({bus.mem_re, bus.core_gnt, bus.core_done} !== 3'b010 || bus.mem_addr !== 16'h0) begin
            errors++;
            $display("FAIL core_read_resp: re/cg/done=%b addr=%h want 010 0000",
                     {bus.mem_re, bus.core_gnt, bus.core_done}, bus.mem_addr);
        end
        tick(); // e2: done cycle
        checks++;
        if (bus.core_done !== 1'b1 || bus.core_gnt !== 1'b0 || bus.core_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL core_read_done: done=%b gnt=%b rdata=%h want 1 0 beef",
                     bus.core_done, bus.core_gnt, bus.core_rdata);
        end
        tick();
        checks++;
        if (bus.core_done !== 1'b0 || bus.core_rdata !== 16'hBEEF || bus.mem_re !== 1'b0) begin
            errors++;
            $display("FAIL core_read_after: done=%b rdata=%h re=%b want 0 beef 0",
                     bus.core_done, bus.core_rdata, bus.mem_re);
        end
    endtask

    task automatic test_ext_write_core_read();
        int done_cnt;
        int we_cnt;
        done_cnt = 0;
        we_cnt   = 0;
        bus.ext_req   = 1'b1;
        bus.ext_we    = 1'b1;
        bus.ext_addr  = 16'h0005;
        bus.ext_wdata = 16'h1234;
        tick(); // ACC
        bus.ext_req   = 1'b0;
        bus.ext_addr  = 16'h0077;
        bus.ext_wdata = 16'hFFFF;
        checks++;
        if ({bus.mem_we, bus.mem_re, bus.ext_gnt, bus.core_gnt} !== 4'b1010 ||
            bus.mem_addr !== 16'h0005 || bus.mem_wdata !== 16'h1234) begin
            errors++;
            $display("FAIL ext_write_acc: we/re/eg/cg=%b addr=%h data=%h want 1010 0005 1234",
                     {bus.mem_we, bus.mem_re, bus.ext_gnt, bus.core_gnt}, bus.mem_addr, bus.mem_wdata);
        end
        for (int i = 0; i < 5; i++) begin
            if (bus.mem_we) we_cnt++;
            tick();
            if (bus.ext_done) done_cnt++;
        end
        checks++;
        if (done_cnt !== 1 || we_cnt !== 1 || ram[5] !== 16'h1234) begin
            errors++;
            $display("FAIL ext_write_pulses: done=%0d we=%0d ram5=%h want 1 1 1234",
                     done_cnt, we_cnt, ram[5]);
        end
        bus.core_req  = 1'b1;
        bus.core_we   = 1'b0;
        bus.core_addr = 16'h0005;
        tick();
        bus.core_req = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.core_done !== 1'b1 || bus.core_rdata !== 16'h1234 || bus.ext_rdata !== 16'h0) begin
            errors++;
            $display("FAIL ext_write_core_read: done=%b core_rdata=%h ext_rdata=%h want 1 1234 0000",
                     bus.core_done, bus.core_rdata, bus.ext_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.core_req  = 1'b1;
        bus.core_we   = 1'b0;
        bus.core_addr = 16'h0010;
        tick(); // ACC #1
        bus.core_addr = 16'h0005;
        tick(); // RESP #1
        tick(); // done #1, request still high
        checks++;
        if (bus.core_done !== 1'b1 || bus.core_gnt !== 1'b0 || bus.core_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL b2b_first: done=%b gnt=%b rdata=%h want 1 0 beef",
                     bus.core_done, bus.core_gnt, bus.core_rdata);
        end
        tick(); // ACC #2, three cycles after ACC #1
        bus.core_req = 1'b0;
        checks++;
        if (bus.core_gnt !== 1'b1 || bus.mem_re !== 1'b1 || bus.mem_addr !== 16'h0005) begin
            errors++;
            $display("FAIL b2b_second: gnt=%b re=%b addr=%h want 1 1 0005",
                     bus.core_gnt, bus.mem_re, bus.mem_addr);
        end
        tick();
        tick();
        checks++;
        if (bus.core_done !== 1'b1 || bus.core_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL b2b_second_done: done=%b rdata=%h want 1 1234", bus.core_done, bus.core_rdata);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [9:0] exp_ext;
        logic [9:0] got_ext;
        int n;
        int both_hi;
        int cyc;
        exp_ext = 10'b1000010000; // bit i = grant i went to ext; order C,C,C,C,E,...
        got_ext = '0;
        n       = 0;
        both_hi = 0;
        cyc     = 0;
        bus.core_req  = 1'b1;
        bus.core_we   = 1'b0;
        bus.core_addr = 16'h0010;
        bus.ext_req   = 1'b1;
        bus.ext_we    = 1'b0;
        bus.ext_addr  = 16'h0005;
        while (n < 10 && cyc < 60) begin
            tick();
            cyc++;
            if (bus.core_gnt && bus.ext_gnt) both_hi++;
            if (bus.mem_re) begin
                got_ext[n] = bus.ext_gnt;
                if (bus.ext_gnt && n == 4) begin
                    checks++;
                    if (dut.wait_cnt_q !== 4'd0) begin
                        errors++;
                        $display("FAIL contention_wait_clear: got %0d want 0", dut.wait_cnt_q);
                    end
                end
                n++;
            end
        end
        bus.core_req = 1'b0;
        bus.ext_req  = 1'b0;
        checks++;
        if (n !== 10 || got_ext !== exp_ext) begin
            errors++;
            $display("FAIL contention_order: grants=%0d ext_bits=%b want 10 %b", n, got_ext, exp_ext);
        end
        checks++;
        if (both_hi !== 0) begin
            errors++;
            $display("FAIL contention_excl: both-gnt cycles=%0d want 0", both_hi);
        end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_simultaneous();
        bus.core_req  = 1'b1;
        bus.core_we   = 1'b0;
        bus.core_addr = 16'h0010;
        bus.ext_req   = 1'b1;
        bus.ext_we    = 1'b0;
        bus.ext_addr  = 16'h0005;
        tick();
        bus.core_req = 1'b0;
        checks++;
        if ({bus.core_gnt, bus.ext_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL simul_first: cg/eg=%b want 10", {bus.core_gnt, bus.ext_gnt});
        end
        tick();
        tick();
        checks++;
        if ({bus.core_done, bus.ext_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL simul_done: cdone/eg=%b want 10", {bus.core_done, bus.ext_gnt});
        end
        tick();
        bus.ext_req = 1'b0;
        checks++;
        if ({bus.core_gnt, bus.ext_gnt} !== 2'b01 || bus.mem_addr !== 16'h0005) begin
            errors++;
            $display("FAIL simul_ext: cg/eg=%b addr=%h want 01 0005", {bus.core_gnt, bus.ext_gnt}, bus.mem_addr);
        end
        tick();
        tick();
        checks++;
        if (bus.ext_done !== 1'b1 || bus.ext_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL simul_ext_done: done=%b rdata=%h want 1 1234", bus.ext_done, bus.ext_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_write();
        int done_cnt;
        done_cnt = 0;
        bus.ext_req   = 1'b1;
        bus.ext_we    = 1'b1;
        bus.ext_addr  = 16'h0033;
        bus.ext_wdata = 16'h5555;
        tick(); // ACC of the write
        bus.ext_req = 1'b0;
        checks++;
        if (bus.mem_we !== 1'b1) begin
            errors++;
            $display("FAIL rst_write_acc: mem_we=%b want 1", bus.mem_we);
        end
        #1;
        Reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_we !== 1'b0 || bus.ext_gnt !== 1'b0 || bus.mem_addr !== 16'h0) begin
            errors++;
            $display("FAIL rst_write_abort: we=%b gnt=%b addr=%h want 0 0 0000",
                     bus.mem_we, bus.ext_gnt, bus.mem_addr);
        end
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.ext_done) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0 || ram[8'h33] !== 16'h0) begin
            errors++;
            $display("FAIL rst_write_nodone: done=%0d ram33=%h want 0 0000", done_cnt, ram[8'h33]);
        end
        checks++;
        if ({bus.core_gnt, bus.ext_gnt, bus.core_done, bus.ext_done, bus.mem_we, bus.mem_re} !== 6'b0 ||
            {bus.core_rdata, bus.ext_rdata} !== 32'h0) begin
            errors++;
            $display("FAIL rst_write_outs: ctrl=%b rdata=%h want 000000 0",
                     {bus.core_gnt, bus.ext_gnt, bus.core_done, bus.ext_done, bus.mem_we, bus.mem_re},
                     {bus.core_rdata, bus.ext_rdata});
        end
        bus.core_req  = 1'b1;
        bus.core_we   = 1'b0;
        bus.core_addr = 16'h0010;
        tick();
        bus.core_req = 1'b0;
        checks++;
        if (bus.core_gnt !== 1'b1 || bus.mem_re !== 1'b1) begin
            errors++;
            $display("FAIL rst_first_req: gnt=%b re=%b want 1 1", bus.core_gnt, bus.mem_re);
        end
        tick();
        tick();
        checks++;
        if (bus.core_done !== 1'b1 || bus.core_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL rst_first_done: done=%b rdata=%h want 1 beef", bus.core_done, bus.core_rdata);
        end
        tick();
    endtask

    task automatic test_withdrawal();
        int acc_cnt;
        int done_cnt;
        acc_cnt  = 0;
        done_cnt = 0;
        bus.core_req  = 1'b1;
        bus.core_we   = 1'b0;
        bus.core_addr = 16'h0005;
        tick(); // ACC
        tick(); // RESP
        bus.core_req = 1'b0;
        tick(); // done
        checks++;
        if (bus.core_done !== 1'b1 || bus.core_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL withdraw_done: done=%b rdata=%h want 1 1234", bus.core_done, bus.core_rdata);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.mem_re || bus.mem_we) acc_cnt++;
            if (bus.core_done) done_cnt++;
        end
        checks++;
        if (acc_cnt !== 0 || done_cnt !== 0) begin
            errors++;
            $display("FAIL withdraw_no_repeat: accesses=%0d dones=%0d want 0 0", acc_cnt, done_cnt);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        bus.mem_rdata = 16'h0;
        for (int i = 0; i < 256; i++) ram[i] = 16'h0;
        ram[8'h10] = 16'hBEEF;

        test_reset();
        test_core_read();
        test_ext_write_core_read();
        test_back_to_back();
        test_contention();
        test_simultaneous();
        test_reset_mid_write();
        test_withdrawal();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port unified instruction/data memory between two requesters. Requester "core" is the multi-cycle control/datapath issuing fetch, lw and sw. Requester "ext" is the program loader/debug port. Core has fixed priority, with a bounded-wait starvation guard for ext; each granted access is a 3-phase sequence against a synchronous-read RAM.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MAX_WAIT, 4, max consecutive core wins while ext is pending before ext is forced through (1..15)

Ports:
CLK  in  1  clock; all state changes on rising edge
Reset  in  1  asynchronous, active-high reset
core_req  in  1  core access request (level)
core_we  in  1  1=write, 0=read
core_addr  in  ADDR_W  core address
core_wdata  in  DATA_W  core write data
core_gnt  out  1  core owns memory (ACC/RESP)
core_done  out  1  one-cycle completion pulse
core_rdata  out  DATA_W  last core read data (held)
ext_req, ext_we, ext_addr, ext_wdata  in  1/1/ADDR_W/DATA_W  same as core
ext_gnt, ext_done, ext_rdata  out  1/1/DATA_W  same as core
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_we  out  1  RAM write strobe
mem_re  out  1  RAM read strobe
mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_re

Behaviour:
- Reset (async, immediate): state=IDLE; owner=none; wait_cnt=0.
- Reset values of outputs: all outputs 0, including mem_we, so an in-flight write is aborted; core_rdata=ext_rdata=0; no done pulse.
- States: IDLE, ACC, RESP.
- IDLE, arbitration at the clock edge:
  - Only core_req=1: grant core.
  - Only ext_req=1: grant ext.
  - Both requests: grant core, unless wait_cnt==MAX_WAIT, in which case grant ext.
  - Neither request: stay in IDLE.
- On grant: latch the winner's we/addr/wdata into internal registers, set owner, go to ACC.
- wait_cnt, updated at each IDLE arbitration edge:
  - +1 (saturating at MAX_WAIT) when core wins while ext_req=1.
  - Cleared to 0 when ext wins or ext_req=0.
- ACC (1 cycle): mem_addr/mem_wdata come from the latched registers. mem_we=latched we; mem_re=!latched we. Go to RESP.
- RESP (1 cycle): mem strobes 0. For a read, at the edge ending RESP, load the owner's rdata register from mem_rdata. At that same edge, set owner's done=1 for exactly the next cycle, clear owner, go to IDLE.
- gnt: owner's gnt=1 during ACC and RESP only; never both gnt high.
- mem_addr/mem_wdata = 0 outside ACC.
- Latency: request sampled at edge e0 -> ACC e0..e1 -> RESP e1..e2 -> done=1 and rdata valid e2..e3. The arbiter is in IDLE during the done cycle.
- Back-to-back: req still high at the edge ending the done cycle is a new request. The minimum access period is 3 cycles.
- Requesters hold we/addr/wdata stable only until the grant edge; latching makes later changes harmless.
- A req dropped during ACC/RESP does not cancel the access: it completes and done still pulses.
- rdata registers hold their value until the next completed read by the same requester. A write never changes rdata.
- Requests arriving in ACC/RESP wait; they are sampled at the next IDLE edge.

Test Plan:
- Core read: RAM[0x0010]=0xBEEF, core_req=1, we=0, addr=0x0010 at e0.
  - -> mem_re=1, mem_addr=0x0010 during e0..e1.
  - -> core_done=1, core_rdata=0xBEEF during e2..e3; core_gnt high e0..e2.
- Ext write then core read: ext writes 0x1234 to 0x0005, then core reads 0x0005.
  - -> mem_we=1 for one cycle with addr 0x0005/data 0x1234; ext_done pulses once.
  - -> core_rdata=0x1234; ext_rdata unchanged (0).
- Contention with MAX_WAIT=4: both reqs held high continuously.
  - -> grant sequence core,core,core,core,ext,core,core,core,core,ext, ...
  - -> wait_cnt returns to 0 after each ext grant.
- Simultaneous single requests: core_req and ext_req rise at the same edge with wait_cnt=0.
  - -> core granted; ext_gnt stays 0 until core_done; ext is granted on the next IDLE edge.
- Reset mid-write: assert Reset during ACC of an ext write.
  - -> mem_we drops to 0 immediately; no ext_done.
  - -> after release all outputs are 0 and the first request is granted normally.
- Request withdrawal: core_req deasserted during RESP of a read.
  - -> core_done still pulses with valid data; no second access issued.
